load_store_buffer: RTL and testbench

MEM-stage load/store unit sitting between the EX/MEM pipeline register and the data memory of the 8-bit RISC-V pipeline. It owns the single data-memory port.

- Stores are posted into a small FIFO store buffer and drained to memory in idle port cycles.
- Loads take the port immediately, with store-to-load forwarding from the buffer.
- Load results are registered toward WB.
- Back-pressure to the pipeline is a single `stall` signal.

---
 rtl/load_store_buffer.sv | 111 +++++++++++
 tb/tb_load_store_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_buffer.sv
// MEM-stage load/store unit: posted store FIFO drained in idle port cycles,
// loads served immediately with youngest-match store forwarding.
module load_store_buffer #(
  parameter int ADDRESS_LINE = 8,
  parameter int DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [ADDRESS_LINE-1:0] req_addr,
  input  logic [7:0]              req_wdata,
  output logic                    stall,
  output logic [7:0]              load_data,
  output logic                    load_valid,
  output logic                    buf_empty,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_LINE-1:0] mem_address,
  output logic [7:0]              mem_write_data,
  input  logic [7:0]              mem_read_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [ADDRESS_LINE-1:0] r_addr [DEPTH];
  logic [7:0]              r_data [DEPTH];
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [PW:0]             r_count;
  logic [7:0]              r_load_data_p1;
  logic                    r_vld_p1;

  logic       w_full;
  logic       w_load_acc;
  logic       w_store_acc;
  logic       w_drain;
  logic [7:0] w_fwd_data;

  assign w_full      = (r_count == FULL_CNT);
  assign w_load_acc  = req_valid & req_read & ~req_write & ~w_full;
  assign w_store_acc = req_valid & req_write & ~w_full;
  // A full buffer always forces a drain; otherwise a load owns the port.
  assign w_drain     = w_full | (~w_load_acc & (r_count != '0));

  assign stall      = req_valid & w_full;
  assign buf_empty  = (r_count == '0);
  assign load_data  = r_load_data_p1;
  assign load_valid = r_vld_p1;

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (w_drain) begin
      mem_write      = 1'b1;
      mem_address    = r_addr[r_head];
      mem_write_data = r_data[r_head];
    end else if (w_load_acc) begin
      mem_read    = 1'b1;
      mem_address = req_addr;
    end
  end

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    w_fwd_data = mem_read_data;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = r_head + PW'(i);
      if (((PW+1)'(i) < r_count) && (r_addr[idx] == req_addr))
        w_fwd_data = r_data[idx];
    end
  end

  // Stage p0 -> p1: buffer pointers and registered load result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_vld_p1       <= 1'b0;
      r_load_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_load_acc;
      if (w_load_acc)
        r_load_data_p1 <= w_fwd_data;
      if (w_store_acc)
        r_tail <= r_tail + PW'(1);
      if (w_drain)
        r_head <= r_head + PW'(1);
      case ({w_store_acc, w_drain})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_store_acc) begin
      r_addr[r_tail] <= req_addr;
      r_data[r_tail] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Bench for load_store_buffer: directed vector table, hand sequences for reset
// and wrap-around, and random traffic against a queue-based reference model.
module tb_load_store_buffer;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_read, req_write;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          stall, load_valid, buf_empty, mem_read, mem_write;
  logic [7:0]    load_data, mem_write_data, mem_read_data;
  logic [AW-1:0] mem_address;

  load_store_buffer #(.ADDRESS_LINE(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .buf_empty(buf_empty), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] a; logic [7:0] d; } ent_t;

  logic [7:0] mem [256];
  ent_t       wlog[$];
  assign mem_read_data = mem[mem_address];
  always @(posedge clock) begin
    if (mem_write) begin
      mem[mem_address] <= mem_write_data;
      wlog.push_back('{mem_address, mem_write_data});
    end
  end

  // Reference model: ordered queue of pending stores plus a memory image.
  ent_t       q[$];
  logic [7:0] mmem [256];
  logic [7:0] m_ld;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setreq(input logic v, input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
    req_valid = v; req_read = r; req_write = w; req_addr = a; req_wdata = d;
  endtask

  task automatic do_reset();
    setreq(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    m_ld = 8'h00;
    mmem = mem;
  endtask

  task automatic mstep(input logic v, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    logic full, ld, st, drain, e_mr, e_mw;
    logic [7:0] e_ma, e_md, e_val;
    ent_t head;
    setreq(v, r, w, a, d);
    full  = (q.size() == DEPTH);
    ld    = v && r && !w && !full;
    st    = v && w && !full;
    drain = full || (!ld && q.size() > 0);
    e_mr = 1'b0; e_mw = 1'b0; e_ma = 8'h00; e_md = 8'h00;
    if (drain) begin
      e_mw = 1'b1; e_ma = q[0].a; e_md = q[0].d;
    end else if (ld) begin
      e_mr = 1'b1; e_ma = a;
    end
    e_val = mmem[a];
    foreach (q[i]) if (q[i].a == a) e_val = q[i].d;
    @(negedge clock);
    chk1("stall", stall, v && full);
    chk1("mem_read", mem_read, e_mr);
    chk1("mem_write", mem_write, e_mw);
    chk8("mem_address", mem_address, e_ma);
    chk8("mem_write_data", mem_write_data, e_md);
    chk1("buf_empty_pre", buf_empty, q.size() == 0);
    @(posedge clock); #1;
    if (drain) begin
      head = q.pop_front();
      mmem[head.a] = head.d;
    end
    if (st) q.push_back('{a, d});
    if (ld) m_ld = e_val;
    chk1("load_valid", load_valid, ld);
    chk8("load_data", load_data, m_ld);
    chk1("buf_empty", buf_empty, q.size() == 0);
  endtask

  typedef struct {
    logic v, r, w; logic [7:0] a, d;
    logic s, mr, mw; logic [7:0] ma, md;
    logic lv; logic [7:0] ld; logic emp;
  } vec_t;
  vec_t tbl[10];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8);
    // Store/drain, forwarding, memory load and no-op vectors from reset.
    tbl[0] = '{1'b1,1'b0,1'b1,8'h20,8'h5A, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0};
    tbl[1] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,8'h20,8'h5A, 1'b0,8'h00,1'b1};
    tbl[2] = '{1'b1,1'b0,1'b1,8'h02,8'h33, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0};
    tbl[3] = '{1'b1,1'b0,1'b1,8'h02,8'h44, 1'b0,1'b0,1'b1,8'h02,8'h33, 1'b0,8'h00,1'b0};
    tbl[4] = '{1'b1,1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h00, 1'b1,8'h44,1'b0};
    tbl[5] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b1,8'h02,8'h44, 1'b0,8'h44,1'b1};
    tbl[6] = '{1'b1,1'b1,1'b0,8'h03,8'h00, 1'b0,1'b1,1'b0,8'h03,8'h00, 1'b1,8'h0B,1'b1};
    tbl[7] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h0B,1'b1};
    tbl[8] = '{1'b1,1'b0,1'b0,8'h07,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h0B,1'b1};
    tbl[9] = '{1'b1,1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h00, 1'b1,8'h44,1'b1};

    setreq(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    #1;
    chk1("rst_stall", stall, 1'b0);
    chk8("rst_load_data", load_data, 8'h00);
    chk1("rst_load_valid", load_valid, 1'b0);
    chk1("rst_buf_empty", buf_empty, 1'b1);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk8("rst_mem_address", mem_address, 8'h00);
    chk8("rst_mem_wdata", mem_write_data, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;

    foreach (tbl[i]) begin
      setreq(tbl[i].v, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
      @(negedge clock);
      chk1("tbl_stall", stall, tbl[i].s);
      chk1("tbl_mem_read", mem_read, tbl[i].mr);
      chk1("tbl_mem_write", mem_write, tbl[i].mw);
      chk8("tbl_mem_address", mem_address, tbl[i].ma);
      chk8("tbl_mem_wdata", mem_write_data, tbl[i].md);
      @(posedge clock); #1;
      chk1("tbl_load_valid", load_valid, tbl[i].lv);
      chk8("tbl_load_data", load_data, tbl[i].ld);
      chk1("tbl_buf_empty", buf_empty, tbl[i].emp);
    end

    // Asynchronous reset mid-cycle with a buffered store pending.
    do_reset();
    mstep(1'b1, 1'b1, 1'b0, 8'h03, 8'h00);
    mstep(1'b1, 1'b0, 1'b1, 8'h40, 8'h77);
    setreq(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk1("pre_rst_mem_write", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    chk1("arst_stall", stall, 1'b0);
    chk8("arst_load_data", load_data, 8'h00);
    chk1("arst_load_valid", load_valid, 1'b0);
    chk1("arst_buf_empty", buf_empty, 1'b1);
    chk1("arst_mem_write", mem_write, 1'b0);
    chk1("arst_mem_read", mem_read, 1'b0);
    chk8("arst_mem_address", mem_address, 8'h00);
    #1;
    reset = 1'b0;
    q.delete();
    m_ld = 8'h00;
    repeat (3) mstep(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    mstep(1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    chk8("discarded_store", load_data, 8'h48);

    // Stores interleaved with loads, then a fifth store.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mstep(1'b1, 1'b0, 1'b1, 8'(8'h50 + k), 8'(k + 1));
      mstep(1'b1, 1'b1, 1'b0, 8'h60, 8'h00);
    end
    mstep(1'b1, 1'b0, 1'b1, 8'h54, 8'h05);
    mstep(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Wrap-around: ten consecutive stores must reach memory in order.
    do_reset();
    wlog.delete();
    for (int k = 0; k < 10; k++) mstep(1'b1, 1'b0, 1'b1, 8'(8'h10 + k), 8'(8'hC0 + k));
    repeat (3) mstep(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk8("wrap_write_count", 8'(wlog.size()), 8'd10);
    for (int k = 0; k < 10 && k < wlog.size(); k++) begin
      chk8("wrap_addr", wlog[k].a, 8'(8'h10 + k));
      chk8("wrap_data", wlog[k].d, 8'(8'hC0 + k));
    end

    // Random traffic on a small address range to exercise forwarding.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [7:0] a, d;
      op = $urandom_range(0, 10);
      a  = 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      case (op)
        0, 1, 2, 3: mstep(1'b1, 1'b0, 1'b1, a, d);
        4, 5, 6, 7: mstep(1'b1, 1'b1, 1'b0, a, d);
        8:          mstep(1'b1, 1'b0, 1'b0, a, d);
        9:          mstep(1'b1, 1'b1, 1'b1, a, d);
        default:    mstep(1'b0, 1'($urandom), 1'($urandom), a, d);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
